// File: rtl/digitaltube_driver_pkg.sv
// rtl/digitaltube_driver_pkg.sv - shared constants and types for the 7-segment tube driver
package digitaltube_driver_pkg;

  // Word offsets inside the device window
  localparam logic [1:0] DATA_OFS = 2'd0;
  localparam logic [1:0] CTRL_OFS = 2'd1;

  // CTRL field positions
  localparam int EN_LSB    = 0;
  localparam int DP_LSB    = 8;
  localparam int BLANK_BIT = 16;
  localparam int CTRL_W    = BLANK_BIT + 1;

  typedef struct packed {
    logic       blank;  // [16]
    logic [7:0] dp;     // [15:8]
    logic [7:0] en;     // [7:0]
  } ctrl_t;

  // Reset values
  localparam logic [31:0] DATA_RST = 32'h0000_0000;
  localparam ctrl_t       CTRL_RST = '{blank: 1'b0, dp: 8'h00, en: 8'hFF};
  localparam logic [7:0]  SEL_OFF  = 8'hFF;
  localparam logic [7:0]  SEG_OFF  = 8'hFF;

  // Active-low g..a patterns for nibbles 0..F; element k is the pattern for value k
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

endpackage

// File: rtl/digitaltube_driver_hex_to_seg.sv
// rtl/digitaltube_driver_hex_to_seg.sv - nibble to active-low 7-segment decoder
// Ports:
//   nibble_i : 4-bit hex value
//   seg_o    : segments g,f,e,d,c,b,a, active-low
module hex_to_seg
  import digitaltube_driver_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_TABLE[nibble_i];

endmodule

// File: rtl/digitaltube_driver.sv
// rtl/digitaltube_driver.sv - bus-mapped driver scanning eight common-anode 7-segment digits
// Ports:
//   clk, clr        : clock, asynchronous active-low reset
//   addr, we, wd    : bridge write side (addr 0 DATA, addr 1 CTRL)
//   rd              : combinational register readback
//   tube_sel        : active-low digit select, at most one bit low
//   tube_seg        : active-low segments, [7]=dp, [6:0]=g..a
module digitaltube_driver
  import digitaltube_driver_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic [7:0]  tube_sel,
  output logic [7:0]  tube_seg
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);

  logic [31:0]   data_q, data_d;
  ctrl_t         ctrl_q, ctrl_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    sel_q, sel_d;
  logic [7:0]    seg_q, seg_d;

  logic          scan_tick;
  logic [3:0]    cur_nibble;
  logic [6:0]    cur_seg7;
  logic          lit;

  // Upper write-data bits have no CTRL field behind them
  logic unused_wd;
  assign unused_wd = ^wd[31:CTRL_W];

  assign scan_tick = (presc_q == PRESC_MAX);

  always_comb begin
    presc_d = scan_tick ? '0 : presc_q + 1'b1;
    idx_d   = scan_tick ? idx_q + 3'd1 : idx_q;
  end

  always_comb begin
    data_d = data_q;
    ctrl_d = ctrl_q;
    if (we) begin
      case (addr)
        DATA_OFS: data_d = wd;
        CTRL_OFS: ctrl_d = ctrl_t'(wd[CTRL_W-1:0]);
        default:  ;
      endcase
    end
  end

  always_comb begin
    rd = '0;
    case (addr)
      DATA_OFS: rd = data_q;
      CTRL_OFS: rd = {{(32-CTRL_W){1'b0}}, ctrl_q};
      default:  rd = '0;
    endcase
  end

  // Output stage is built from registered state only, so writes and idx
  // changes show up one edge later.
  assign cur_nibble = 4'(data_q >> {idx_q, 2'b00});

  hex_to_seg u_hex_to_seg (
    .nibble_i (cur_nibble),
    .seg_o    (cur_seg7)
  );

  assign lit = !ctrl_q.blank && ctrl_q.en[idx_q];

  always_comb begin
    sel_d = SEL_OFF;
    seg_d = SEG_OFF;
    if (lit) begin
      sel_d = ~(8'h01 << idx_q);
      seg_d = {~ctrl_q.dp[idx_q], cur_seg7};
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      data_q  <= DATA_RST;
      ctrl_q  <= CTRL_RST;
      presc_q <= '0;
      idx_q   <= 3'd0;
      sel_q   <= SEL_OFF;
      seg_q   <= SEG_OFF;
    end else begin
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      seg_q   <= seg_d;
    end
  end

  assign tube_sel = sel_q;
  assign tube_seg = seg_q;

endmodule
